vscale_htif_pcr_arbiter: RTL and testbench

- Shares the single HTIF PCR request/response port of the CSR file between two host-side requesters, e.g. the HTIF host link (requester 0) and a debug/test harness (requester 1).
- Holds at most one transaction in flight: it latches the winning request, issues it downstream, captures the response and returns it to the owner.
- Arbitration is round-robin by default and fixed-priority when the optional feature is compiled in.

---
 rtl/vscale_htif_pcr_arbiter.sv | 125 ++++++++++++
 tb/tb_vscale_htif_pcr_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vscale_htif_pcr_arbiter.sv
// Two-requester arbiter in front of the CSR file's single HTIF PCR port; one transaction in flight.
// Round-robin by default; define VSCALE_PCR_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module vscale_htif_pcr_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_rw,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_rw,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic [DATA_WIDTH-1:0] resp0_data,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp1_data,
    output logic                  pcr_req_valid,
    input  logic                  pcr_req_ready,
    output logic                  pcr_req_rw,
    output logic [ADDR_WIDTH-1:0] pcr_req_addr,
    output logic [DATA_WIDTH-1:0] pcr_req_data,
    input  logic                  pcr_resp_valid,
    output logic                  pcr_resp_ready,
    input  logic [DATA_WIDTH-1:0] pcr_resp_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RETURN
    } state_t;

    state_t                state;
    logic                  owner;
    logic [DATA_WIDTH-1:0] resp_q;
    logic                  win;
    logic                  any_valid;
    logic                  owner_ack;

    assign any_valid = req0_valid | req1_valid;
    assign owner_ack = owner ? resp1_ready : resp0_ready;

`ifdef VSCALE_PCR_ARB_FIXED_PRIO_EN
    assign win = ~req0_valid;
`else
    logic rr;
    // rr names the tie winner; a lone requester wins regardless of rr
    assign win = (req0_valid & req1_valid) ? rr : req1_valid;
`endif

    assign req0_ready = (state == S_IDLE) & req0_valid & ~win;
    assign req1_ready = (state == S_IDLE) & req1_valid & win;

    // Response data is shared; only the owner's valid qualifies it
    assign resp0_data = resp_q;
    assign resp1_data = resp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            owner          <= 1'b0;
            pcr_req_rw     <= 1'b0;
            pcr_req_addr   <= '0;
            pcr_req_data   <= '0;
            resp_q         <= '0;
            pcr_req_valid  <= 1'b0;
            pcr_resp_ready <= 1'b0;
            resp0_valid    <= 1'b0;
            resp1_valid    <= 1'b0;
`ifndef VSCALE_PCR_ARB_FIXED_PRIO_EN
            rr             <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        owner         <= win;
                        pcr_req_rw    <= win ? req1_rw   : req0_rw;
                        pcr_req_addr  <= win ? req1_addr : req0_addr;
                        pcr_req_data  <= win ? req1_data : req0_data;
                        pcr_req_valid <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (pcr_req_ready) begin
                        pcr_req_valid  <= 1'b0;
                        pcr_resp_ready <= 1'b1;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pcr_resp_valid) begin
                        resp_q         <= pcr_resp_data;
                        pcr_resp_ready <= 1'b0;
                        resp0_valid    <= ~owner;
                        resp1_valid    <= owner;
                        state          <= S_RETURN;
                    end
                end
                S_RETURN: begin
                    if (owner_ack) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
`ifndef VSCALE_PCR_ARB_FIXED_PRIO_EN
                        rr          <= ~owner;
`endif
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
// Directed bench for vscale_htif_pcr_arbiter with a two-entry CSR model (0x780, 0x781).
module tb_vscale_htif_pcr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_rw;
    logic [11:0] req0_addr;
    logic [63:0] req0_data;
    logic        req1_valid, req1_ready, req1_rw;
    logic [11:0] req1_addr;
    logic [63:0] req1_data;
    logic        resp0_valid, resp0_ready;
    logic [63:0] resp0_data;
    logic        resp1_valid, resp1_ready;
    logic [63:0] resp1_data;
    logic        pcr_req_valid, pcr_req_ready, pcr_req_rw;
    logic [11:0] pcr_req_addr;
    logic [63:0] pcr_req_data;
    logic        pcr_resp_valid, pcr_resp_ready;
    logic [63:0] pcr_resp_data;

    int checks = 0;
    int failures = 0;
    logic [63:0] csr [2];

    always #5 clk = ~clk;

    vscale_htif_pcr_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
        .pcr_req_valid(pcr_req_valid), .pcr_req_ready(pcr_req_ready), .pcr_req_rw(pcr_req_rw),
        .pcr_req_addr(pcr_req_addr), .pcr_req_data(pcr_req_data),
        .pcr_resp_valid(pcr_resp_valid), .pcr_resp_ready(pcr_resp_ready),
        .pcr_resp_data(pcr_resp_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are checked 2 time units after each rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req0_rw = 0; req0_addr = '0; req0_data = '0;
        req1_valid = 0; req1_rw = 0; req1_addr = '0; req1_data = '0;
        resp0_ready = 0; resp1_ready = 0;
        pcr_req_ready = 0; pcr_resp_valid = 0; pcr_resp_data = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        step();
        step();
        chk("rst_pcr_req_valid", pcr_req_valid, 0);
        chk("rst_pcr_resp_ready", pcr_resp_ready, 0);
        chk("rst_resp0_valid", resp0_valid, 0);
        chk("rst_resp1_valid", resp1_valid, 0);
        chk("rst_pcr_req_addr", pcr_req_addr, 0);
        chk("rst_resp0_data", resp0_data, 0);
        reset = 0;
    endtask

    // Called in the IDLE cycle with requester inputs already driven; runs one
    // transaction for the expected winner with optional downstream/response stalls.
    task automatic txn(input string tag, input int who, input int req_stall, input int resp_stall);
        logic        erw;
        logic [11:0] ea;
        logic [63:0] ed, rd;
        erw = (who == 1) ? req1_rw : req0_rw;
        ea  = (who == 1) ? req1_addr : req0_addr;
        ed  = (who == 1) ? req1_data : req0_data;
        #1;
        chk({tag, "_grant0"}, req0_ready, who == 0);
        chk({tag, "_grant1"}, req1_ready, who == 1);
        step();
        if (who == 1) req1_valid = 0; else req0_valid = 0;
        for (int i = 0; i <= req_stall; i++) begin
            chk({tag, "_issue_valid"}, pcr_req_valid, 1);
            chk({tag, "_issue_rw"}, pcr_req_rw, erw);
            chk({tag, "_issue_addr"}, pcr_req_addr, ea);
            chk({tag, "_issue_data"}, pcr_req_data, ed);
            chk({tag, "_issue_rdy0"}, req0_ready, 0);
            chk({tag, "_issue_rdy1"}, req1_ready, 0);
            if (i == req_stall) pcr_req_ready = 1;
            step();
        end
        pcr_req_ready = 0;
        chk({tag, "_wait_resp_ready"}, pcr_resp_ready, 1);
        chk({tag, "_wait_req_valid"}, pcr_req_valid, 0);
        if (erw) csr[ea[0]] = ed;
        rd = csr[ea[0]];
        pcr_resp_valid = 1;
        pcr_resp_data = rd;
        step();
        pcr_resp_valid = 0;
        pcr_resp_data = '0;
        for (int i = 0; i <= resp_stall; i++) begin
            chk({tag, "_ret_own_valid"}, (who == 1) ? resp1_valid : resp0_valid, 1);
            chk({tag, "_ret_other_valid"}, (who == 1) ? resp0_valid : resp1_valid, 0);
            chk({tag, "_ret_data"}, (who == 1) ? resp1_data : resp0_data, rd);
            chk({tag, "_ret_resp_ready"}, pcr_resp_ready, 0);
            if (i == resp_stall) begin
                if (who == 1) resp1_ready = 1; else resp0_ready = 1;
            end
            step();
        end
        resp0_ready = 0;
        resp1_ready = 0;
        chk({tag, "_done_valid0"}, resp0_valid, 0);
        chk({tag, "_done_valid1"}, resp1_valid, 0);
    endtask

    initial begin
        csr[0] = 64'h1234;
        csr[1] = 64'h0;
        do_reset();

        // Lone read of to_host
        req0_valid = 1; req0_rw = 0; req0_addr = 12'h780;
        txn("t1", 0, 0, 0);

        // Tie from reset: req0 first, then arbitration order depends on build
        do_reset();
        req0_valid = 1; req0_rw = 0; req0_addr = 12'h780;
        req1_valid = 1; req1_rw = 0; req1_addr = 12'h781;
        txn("t2a", 0, 0, 0);
        req0_valid = 1;
`ifdef VSCALE_PCR_ARB_FIXED_PRIO_EN
        txn("t2b", 0, 0, 0);
        txn("t2c", 1, 0, 0);
`else
        txn("t2b", 1, 0, 0);
        txn("t2c", 0, 0, 0);
`endif

        // Downstream holds off request acceptance for 5 cycles
        req0_valid = 1; req0_rw = 0; req0_addr = 12'h780; req0_data = 64'hA5A5;
        txn("t3", 0, 5, 0);

        // req1 write with requester stalling the response for 3 cycles
        req1_valid = 1; req1_rw = 1; req1_addr = 12'h781; req1_data = 64'hDEAD_BEEF;
        txn("t4", 1, 0, 3);

        // Tie after req1 owned the port: req0 wins, reads back the written value
        req0_valid = 1; req0_rw = 0; req0_addr = 12'h781; req0_data = '0;
        req1_valid = 1; req1_rw = 0; req1_addr = 12'h780; req1_data = '0;
        txn("t5a", 0, 0, 0);
        txn("t5b", 1, 0, 0);

        // Reset while waiting on the CSR response
        req0_valid = 1; req0_rw = 0; req0_addr = 12'h780;
        #1;
        chk("t6_grant0", req0_ready, 1);
        step();
        req0_valid = 0;
        chk("t6_issue_valid", pcr_req_valid, 1);
        pcr_req_ready = 1;
        step();
        pcr_req_ready = 0;
        chk("t6_wait_resp_ready", pcr_resp_ready, 1);
        reset = 1;
        pcr_resp_valid = 1;
        pcr_resp_data = 64'h5555;
        step();
        reset = 0;
        pcr_resp_valid = 0;
        chk("t6_rst_req_valid", pcr_req_valid, 0);
        chk("t6_rst_resp_ready", pcr_resp_ready, 0);
        chk("t6_rst_resp0_valid", resp0_valid, 0);
        chk("t6_rst_resp1_valid", resp1_valid, 0);
        chk("t6_rst_req0_ready", req0_ready, 0);
        chk("t6_rst_req1_ready", req1_ready, 0);
        chk("t6_rst_resp_data", resp0_data, 0);
        step();
        chk("t6_dropped_resp0", resp0_valid, 0);
        req0_valid = 1; req0_rw = 0; req0_addr = 12'h780;
        txn("t6b", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
